led_group_ctrl: RTL and testbench

LED_GROUP_CTRL -- requirements
Module: led_group_ctrl

---
 rtl/led_ctrl_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/led_group_ctrl.sv | 101 ++++++++++
 tb/tb_led_group_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared constants and types for the LED group controller.
// Pure declarations: no latency, no flow control.
// Holds the group count, FSM state encoding and the default debounce/scan timing.
package led_ctrl_pkg;

    localparam int          NUM_GROUPS          = 4;
    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [31:0] DEF_SCAN_PERIOD     = 32'd25000000;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } ctrl_state_t;

    // One-position left rotation of a group mask, MSB wraps into LSB.
    function automatic logic [NUM_GROUPS-1:0] rotl1(input logic [NUM_GROUPS-1:0] v);
        return {v[NUM_GROUPS-2:0], v[NUM_GROUPS-1]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one push-button and emits a one-cycle rise pulse.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 cycles from a clean step to the pulse.
// No backpressure: the pulse is a free-running single-cycle strobe.
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic rise
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic        level_prev;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= 16'd0;
            rise       <= 1'b0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            level_prev <= level;
            rise       <= level & ~level_prev;
            // Level is accepted on the edge where the count would reach the threshold.
            if (sync2 == level) begin
                cnt <= 16'd0;
            end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
                level <= sync2;
                cnt   <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/led_group_ctrl.sv
// Drives the LED group blanking mask from debounced buttons (MANUAL) or a rotating scan (SCAN).
// Latency: mask/group_off update the edge after a btn_event; SCAN entry 3 edges after mode_sel.
// No backpressure: all outputs are free-running registers.
module led_group_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [31:0] SCAN_PERIOD     = DEF_SCAN_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_GROUPS-1:0] btn_raw,
    input  logic                  mode_sel,
    output logic [NUM_GROUPS-1:0] group_off,
    output logic [NUM_GROUPS-1:0] btn_event,
    output logic                  scan_active
);

    localparam logic [NUM_GROUPS-1:0] FIRST_GROUP = {{(NUM_GROUPS-1){1'b0}}, 1'b1};

    ctrl_state_t           state;
    ctrl_state_t           state_nxt;
    logic                  mode_sync1;
    logic                  mode_sync2;
    logic [NUM_GROUPS-1:0] manual_mask;
    logic [NUM_GROUPS-1:0] mask_nxt;
    logic [NUM_GROUPS-1:0] group_off_nxt;
    logic [31:0]           scan_cnt;
    logic [31:0]           scan_cnt_nxt;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[g]),
            .rise   (btn_event[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sync1 <= 1'b0;
            mode_sync2 <= 1'b0;
            state      <= MANUAL;
        end else begin
            mode_sync1 <= mode_sel;
            mode_sync2 <= mode_sync1;
            state      <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MANUAL:  if (mode_sync2)  state_nxt = SCAN;
            SCAN:    if (!mode_sync2) state_nxt = MANUAL;
            default: state_nxt = MANUAL;
        endcase
    end

    // Outputs are computed from the upcoming state so they are valid on the first cycle of it.
    always_comb begin
        mask_nxt      = manual_mask;
        group_off_nxt = group_off;
        scan_cnt_nxt  = scan_cnt;
        if (state == MANUAL) begin
            mask_nxt = manual_mask ^ btn_event;
        end
        if (state_nxt == SCAN) begin
            if (state == MANUAL) begin
                group_off_nxt = FIRST_GROUP;
                scan_cnt_nxt  = 32'd0;
            end else if (scan_cnt == SCAN_PERIOD - 32'd1) begin
                group_off_nxt = rotl1(group_off);
                scan_cnt_nxt  = 32'd0;
            end else begin
                scan_cnt_nxt  = scan_cnt + 32'd1;
            end
        end else begin
            group_off_nxt = mask_nxt;
            scan_cnt_nxt  = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            manual_mask <= '0;
            group_off   <= '0;
            scan_cnt    <= 32'd0;
            scan_active <= 1'b0;
        end else begin
            manual_mask <= mask_nxt;
            group_off   <= group_off_nxt;
            scan_cnt    <= scan_cnt_nxt;
            scan_active <= (state_nxt == SCAN);
        end
    end

endmodule

// File: tb/tb_led_group_ctrl.sv
// Self-checking bench for led_group_ctrl with DEBOUNCE_CYCLES=4, SCAN_PERIOD=8.
// Expectations are queued per absolute cycle and compared on the falling edge.
module tb_led_group_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       mode_sel;
    logic [3:0] group_off;
    logic [3:0] btn_event;
    logic       scan_active;

    int cyc     = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] ev;
        logic [3:0] go;
        logic       sa;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] ev;
        logic [3:0] go;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[6];

    led_group_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .SCAN_PERIOD    (32'd8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .mode_sel   (mode_sel),
        .group_off  (group_off),
        .btn_event  (btn_event),
        .scan_active(scan_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not evaluated (now %0d)", e.name, e.cyc, cyc);
            end else if ({btn_event, group_off, scan_active} !== {e.ev, e.go, e.sa}) begin
                n_fail++;
                $display("FAIL %s @%0d: got event=%b group_off=%b scan=%b, want event=%b group_off=%b scan=%b",
                         e.name, cyc, btn_event, group_off, scan_active, e.ev, e.go, e.sa);
            end
        end
    end

    task automatic push(input int k, input string nm, input logic [3:0] ev,
                        input logic [3:0] go, input logic sa);
        exp_t x;
        x.cyc  = k;
        x.name = nm;
        x.ev   = ev;
        x.go   = go;
        x.sa   = sa;
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] scan_go(input int idx);
        logic [3:0] r;
        case (idx % 4)
            0:       r = 4'b0001;
            1:       r = 4'b0010;
            2:       r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

    initial begin
        int         c;
        logic [3:0] prev;

        // btn pattern pressed, expected rise mask, expected group_off after the press
        vecs[0] = '{btn: 4'b0001, ev: 4'b0001, go: 4'b0001};
        vecs[1] = '{btn: 4'b0010, ev: 4'b0010, go: 4'b0011};
        vecs[2] = '{btn: 4'b1010, ev: 4'b1010, go: 4'b1001};
        vecs[3] = '{btn: 4'b0100, ev: 4'b0100, go: 4'b1101};
        vecs[4] = '{btn: 4'b1111, ev: 4'b1111, go: 4'b0010};
        vecs[5] = '{btn: 4'b0100, ev: 4'b0100, go: 4'b0110};

        rst      = 1'b1;
        btn_raw  = 4'b0000;
        mode_sel = 1'b0;
        tick(2);
        push(cyc + 1, "reset", 4'b0000, 4'b0000, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Manual presses: event exactly at drive+7, mask visible at drive+8, release is silent.
        prev = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            c = cyc;
            push(c + 6, $sformatf("press%0d_pre", i),  4'b0000,    prev,       1'b0);
            push(c + 7, $sformatf("press%0d_evt", i),  vecs[i].ev, prev,       1'b0);
            push(c + 8, $sformatf("press%0d_post", i), 4'b0000,    vecs[i].go, 1'b0);
            btn_raw = vecs[i].btn;
            tick(10);
            c = cyc;
            for (int k = 6; k <= 8; k++)
                push(c + k, $sformatf("release%0d", i), 4'b0000, vecs[i].go, 1'b0);
            btn_raw = 4'b0000;
            tick(10);
            prev = vecs[i].go;
        end

        // Bounce on button 2 shorter than the debounce window.
        c = cyc;
        for (int k = 1; k <= 28; k++)
            push(c + k, "bounce", 4'b0000, 4'b0110, 1'b0);
        for (int i = 0; i < 5; i++) begin
            btn_raw = 4'b0100;
            tick(2);
            btn_raw = 4'b0000;
            tick(2);
        end
        tick(10);

        // Scan rotation with a button press that must pulse but not alter the mask.
        c = cyc;
        for (int k = c + 1; k <= c + 46; k++) begin
            if (k <= c + 2 || k >= c + 43)
                push(k, "scan_manual", 4'b0000, 4'b0110, 1'b0);
            else
                push(k, "scan_rot", (k == c + 12) ? 4'b1000 : 4'b0000, scan_go((k - c - 3) / 8), 1'b1);
        end
        mode_sel = 1'b1;
        tick(5);
        btn_raw = 4'b1000;
        tick(15);
        btn_raw = 4'b0000;
        tick(20);
        mode_sel = 1'b0;
        tick(10);

        // Reset mid-scan while button 0 is part-way through debouncing.
        c = cyc;
        for (int k = c + 1; k <= c + 2; k++)
            push(k, "rst_pre_manual", 4'b0000, 4'b0110, 1'b0);
        for (int k = c + 3; k <= c + 13; k++)
            push(k, "rst_pre_scan", 4'b0000, (k <= c + 10) ? 4'b0001 : 4'b0010, 1'b1);
        push(c + 14, "rst_clear", 4'b0000, 4'b0000, 1'b0);
        for (int k = c + 15; k <= c + 20; k++)
            push(k, "rst_no_early_evt", 4'b0000, 4'b0000, 1'b0);
        push(c + 21, "rst_held_evt", 4'b0001, 4'b0000, 1'b0);
        for (int k = c + 22; k <= c + 24; k++)
            push(k, "rst_held_mask", 4'b0000, 4'b0001, 1'b0);
        mode_sel = 1'b1;
        tick(10);
        btn_raw = 4'b0001;
        tick(3);
        rst      = 1'b1;
        mode_sel = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(12);
        btn_raw = 4'b0000;
        tick(10);
        @(negedge clk);
        #1;

        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never evaluated", e.name, e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
